opu_engine: RTL and testbench
=============================

OPU_ENGINE -- requirements
Module: opu_engine

Interface
REQ-001 clk  input  1  single block clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 op_code  input  2  operation select: 00 ADD, 01 SUB, 11 MUL, 10 LOAD.
REQ-004 data  input  8  unsigned operand byte.
REQ-005 op_start  input  1  level request from server; held high until the cycle after op_done.
REQ-006 op_done  output  1  registered completion pulse, high exactly one cycle per operation.
REQ-007 result  output  16  accumulator value.
REQ-008 carry  output  1  ADD carry-out / SUB borrow of the last operation.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 States: IDLE, EXEC, DONE, REARM; Moore outputs only.
REQ-011 IDLE with op_start=1 at edge k: latch op_code and data, go to EXEC, load iteration count (1 for ADD/SUB/LOAD, 8 for MUL).
REQ-012 op_code/data changes after the accepting edge are ignored until the next acceptance.
REQ-013 ADD: result <= result + data (zero-extended), modulo 2^16; carry <= bit 16 of the sum.
REQ-014 SUB: result <= result - data, modulo 2^16; carry <= 1 iff data > result.
REQ-015 LOAD: result <= {8'h00, data}; carry <= 0.
REQ-016 MUL: result <= result[7:0] * data, exact 16-bit product; carry <= 0; one shift-add step per EXEC cycle, LSB of multiplier first.
REQ-017 Intermediate MUL partial products are not visible on result; result updates once, at the final EXEC edge.
REQ-018 Last EXEC edge (k+1 single-cycle ops, k+8 MUL) -> DONE; op_done=1 for the whole DONE cycle.
REQ-019 DONE edge: op_start=0 -> IDLE; op_start=1 -> REARM.
REQ-020 REARM: remain until op_start sampled 0, then -> IDLE; no operation is accepted while op_start stays high after completion.
REQ-021 A held-high op_start never triggers a second operation; a new request requires op_start low for at least one edge.
REQ-022 op_start deasserting during EXEC does not abort; the operation completes and op_done still pulses.
REQ-023 busy=1 in EXEC, DONE, REARM; 0 in IDLE.

Reset
REQ-024 rst=1 at an edge: state IDLE, result 16'h0000, carry 0, op_done 0, busy 0, iteration counter 0.
REQ-025 Reset mid-EXEC aborts the operation with no result update and no op_done pulse.
REQ-026 rst=1 with op_start=1 in the same edge: reset wins; request sampled earliest at the first edge with rst=0.

Structure
REQ-027 Shared package opu_pkg holds op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_LOAD) and the state encoding; the server FSM uses the same op-code constants.
REQ-028 One sub-module, opu_mul_seq: 8-step shift-add multiplier with start, 8x8 operands, 16-bit product and done; all other logic lives in opu_engine.

Verification
REQ-029 Reset, LOAD data=8'h34 -> op_done 2 edges after acceptance, result 16'h0034, carry 0, one pulse only.
REQ-030 result=16'hFFF0, ADD data=8'h20 -> result 16'h0010, carry 1; then SUB data=8'h11 -> result 16'hFFFF, carry 1.
REQ-031 result=16'h00FF, MUL data=8'hFF -> op_done 9 edges after acceptance, result 16'hFE01; result unchanged during EXEC.
REQ-032 op_start held high 5 cycles after op_done -> single op_done pulse, state REARM until low, busy stays 1.
REQ-033 data changed to 8'h99 during MUL EXEC, operand 8'h03, result 16'h0005 -> result 16'h000F.
REQ-034 rst pulsed at the 4th EXEC cycle of MUL -> no op_done, result 16'h0000, next request accepted normally.

Source files
------------

// File: rtl/opu_pkg.sv
// Shared definitions for the operand processing unit: op-code values,
// controller state encoding and iteration counts.
package opu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [3:0] ITER_SINGLE = 4'd1;
    localparam logic [3:0] ITER_MUL    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DONE  = 2'd2,
        ST_REARM = 2'd3
    } opu_state_e;

    // Number of EXEC cycles an operation occupies.
    function automatic logic [3:0] iter_count(input logic [1:0] op);
        return (op == OP_MUL) ? ITER_MUL : ITER_SINGLE;
    endfunction

endpackage

// File: rtl/opu_mul_seq.sv
// 8x8 shift-add multiplier, one partial-product step per step_i cycle,
// multiplier LSB first. product_o is the accumulator value including the
// current step, so the caller can capture the final product on the same
// edge that performs the last step.
module opu_mul_seq
    import opu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] product_o,
    output logic        done_o
);

    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        act_q, act_d;
    logic [15:0] sum;

    // Partial sum for the step being executed this cycle.
    always_comb begin
        sum = acc_q + (b_q[0] ? a_q : 16'h0000);
    end

    // Operand load on start, otherwise shift and accumulate on each step.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        act_d = act_q;
        if (start_i) begin
            a_d   = {8'h00, a_i};
            b_d   = b_i;
            acc_d = 16'h0000;
            cnt_d = 3'd0;
            act_d = 1'b1;
        end else if (step_i && act_q) begin
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            acc_d = sum;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                act_d = 1'b0;
            end
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= 16'h0000;
            b_q   <= 8'h00;
            acc_q <= 16'h0000;
            cnt_q <= 3'd0;
            act_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign product_o = sum;
    assign done_o    = act_q && step_i && (cnt_q == 3'd7);

endmodule

// File: rtl/opu_engine.sv
// Operand processing unit: accepts one operation per op_start request,
// applies it to the 16-bit accumulator and pulses op_done once.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for op_start; operands latched on acceptance
// ST_EXEC  | executing; 1 cycle for ADD/SUB/LOAD, 8 for MUL
// ST_DONE  | op_done high for this single cycle
// ST_REARM | op_start still high after completion; wait for it to drop
module opu_engine
    import opu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  op_code,
    input  logic [7:0]  data,
    input  logic        op_start,
    output logic        op_done,
    output logic [15:0] result,
    output logic        carry,
    output logic        busy
);

    opu_state_e  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;

    logic        mul_start;
    logic        mul_step;
    logic [15:0] mul_product;
    logic        mul_done;
    logic        last_exec;
    logic [16:0] add_sum;
    logic [15:0] sub_diff;

    opu_mul_seq u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .a_i       (result_q[7:0]),
        .b_i       (data),
        .product_o (mul_product),
        .done_o    (mul_done)
    );

    // Single-cycle arithmetic on the latched operand.
    always_comb begin
        add_sum  = {1'b0, result_q} + {9'h000, data_q};
        sub_diff = result_q - {8'h00, data_q};
    end

    // Next-state, operand latch and accumulator update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        carry_d   = carry_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        last_exec = (op_q == OP_MUL) ? mul_done : (cnt_q == 4'd1);
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    op_d      = op_code;
                    data_d    = data;
                    cnt_d     = iter_count(op_code);
                    mul_start = (op_code == OP_MUL);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                mul_step = (op_q == OP_MUL);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (last_exec) begin
                    state_d = ST_DONE;
                    case (op_q)
                        OP_ADD: begin
                            result_d = add_sum[15:0];
                            carry_d  = add_sum[16];
                        end
                        OP_SUB: begin
                            result_d = sub_diff;
                            carry_d  = ({8'h00, data_q} > result_q);
                        end
                        OP_LOAD: begin
                            result_d = {8'h00, data_q};
                            carry_d  = 1'b0;
                        end
                        default: begin
                            result_d = mul_product;
                            carry_d  = 1'b0;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = op_start ? ST_REARM : ST_IDLE;
            end
            default: begin
                if (!op_start) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset takes priority over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            data_q   <= 8'h00;
            cnt_q    <= 4'd0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign op_done = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);
    assign result  = result_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_opu_engine.sv
// Directed bench for opu_engine with hand-computed expected values.
module tb_opu_engine;
    import opu_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  op_code;
    logic [7:0]  data;
    logic        op_start;
    logic        op_done;
    logic [15:0] result;
    logic        carry;
    logic        busy;

    int checks;
    int errors;
    int pulses;

    opu_engine dut (
        .clk      (clk),
        .rst      (rst),
        .op_code  (op_code),
        .data     (data),
        .op_start (op_start),
        .op_done  (op_done),
        .result   (result),
        .carry    (carry),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count op_done pulses as seen at each edge.
    always @(posedge clk) begin
        if (op_done === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation. edges counts the accepting edge as 1 and stops
    // at the edge that raises op_done. After acceptance the operand inputs
    // are overwritten with scr to confirm they are ignored. hold_n keeps
    // op_start high for that many extra cycles after op_done.
    task automatic do_op(input string tag, input logic [1:0] code, input logic [7:0] d,
                         input logic [7:0] scr, input int hold_n, output int edges);
        logic [15:0] pre;
        int          p0;
        pre      = result;
        p0       = pulses;
        op_code  = code;
        data     = d;
        op_start = 1'b1;
        tick();
        edges = 1;
        chk({tag, "_busy_acc"}, {31'b0, busy}, 32'd1);
        data    = scr;
        op_code = ~code;
        while (op_done !== 1'b1 && edges < 20) begin
            chk({tag, "_hold"}, {16'b0, result}, {16'b0, pre});
            tick();
            edges++;
        end
        chk({tag, "_timeout"}, {31'b0, op_done}, 32'd1);
        for (int i = 0; i < hold_n; i++) begin
            tick();
            chk({tag, "_rearm_done"}, {31'b0, op_done}, 32'd0);
            chk({tag, "_rearm_busy"}, {31'b0, busy}, 32'd1);
        end
        op_start = 1'b0;
        tick();
        chk({tag, "_idle_done"}, {31'b0, op_done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_pulses"}, pulses - p0, 32'd1);
    endtask

    initial begin
        int e;
        checks   = 0;
        errors   = 0;
        pulses   = 0;
        rst      = 1'b1;
        op_start = 1'b1;
        op_code  = OP_LOAD;
        data     = 8'h34;
        tick();
        tick();
        chk("rst_busy",   {31'b0, busy},    32'd0);
        chk("rst_done",   {31'b0, op_done}, 32'd0);
        chk("rst_result", {16'b0, result},  32'h0000);
        chk("rst_carry",  {31'b0, carry},   32'd0);
        op_start = 1'b0;
        rst      = 1'b0;
        tick();

        do_op("load34", OP_LOAD, 8'h34, 8'hAA, 0, e);
        chk("load34_lat", e, 32'd2);
        chk("load34_res", {16'b0, result}, 32'h0034);
        chk("load34_cy",  {31'b0, carry},  32'd0);

        do_op("load00", OP_LOAD, 8'h00, 8'h55, 0, e);
        do_op("sub10", OP_SUB, 8'h10, 8'h00, 0, e);
        chk("sub10_res", {16'b0, result}, 32'hFFF0);
        chk("sub10_cy",  {31'b0, carry},  32'd1);

        do_op("add20", OP_ADD, 8'h20, 8'h77, 0, e);
        chk("add20_lat", e, 32'd2);
        chk("add20_res", {16'b0, result}, 32'h0010);
        chk("add20_cy",  {31'b0, carry},  32'd1);

        do_op("sub11", OP_SUB, 8'h11, 8'h01, 0, e);
        chk("sub11_res", {16'b0, result}, 32'hFFFF);
        chk("sub11_cy",  {31'b0, carry},  32'd1);

        do_op("loadff", OP_LOAD, 8'hFF, 8'h00, 0, e);
        chk("loadff_cy", {31'b0, carry}, 32'd0);
        do_op("mulff", OP_MUL, 8'hFF, 8'h00, 0, e);
        chk("mulff_lat", e, 32'd9);
        chk("mulff_res", {16'b0, result}, 32'hFE01);
        chk("mulff_cy",  {31'b0, carry},  32'd0);

        do_op("hold5", OP_LOAD, 8'h05, 8'h44, 5, e);
        chk("hold5_res", {16'b0, result}, 32'h0005);

        do_op("mul03", OP_MUL, 8'h03, 8'h99, 0, e);
        chk("mul03_lat", e, 32'd9);
        chk("mul03_res", {16'b0, result}, 32'h000F);

        do_op("add01", OP_ADD, 8'h01, 8'hFF, 0, e);
        chk("add01_res", {16'b0, result}, 32'h0010);
        chk("add01_cy",  {31'b0, carry},  32'd0);
        do_op("sub10eq", OP_SUB, 8'h10, 8'hFF, 0, e);
        chk("sub10eq_res", {16'b0, result}, 32'h0000);
        chk("sub10eq_cy",  {31'b0, carry},  32'd0);

        // Reset during the 4th EXEC cycle of a multiply.
        do_op("load07", OP_LOAD, 8'h07, 8'h00, 0, e);
        begin
            int p0;
            p0       = pulses;
            op_code  = OP_MUL;
            data     = 8'h05;
            op_start = 1'b1;
            tick();
            tick();
            tick();
            tick();
            chk("abort_busy_pre", {31'b0, busy}, 32'd1);
            chk("abort_res_pre", {16'b0, result}, 32'h0007);
            rst      = 1'b1;
            op_start = 1'b0;
            tick();
            rst = 1'b0;
            chk("abort_res",  {16'b0, result},  32'h0000);
            chk("abort_busy", {31'b0, busy},    32'd0);
            chk("abort_done", {31'b0, op_done}, 32'd0);
            for (int i = 0; i < 8; i++) tick();
            chk("abort_pulses", pulses - p0, 32'd0);
            chk("abort_res2", {16'b0, result}, 32'h0000);
        end

        do_op("load0c", OP_LOAD, 8'h0C, 8'h00, 0, e);
        chk("load0c_res", {16'b0, result}, 32'h000C);
        do_op("mul0b", OP_MUL, 8'h0B, 8'h00, 0, e);
        chk("mul0b_lat", e, 32'd9);
        chk("mul0b_res", {16'b0, result}, 32'h0084);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
